// File: rtl/edge_pkg.sv
// Shared encodings for the debounced edge detector: edge-mode codes and the
// two-state debounce FSM encoding.
package edge_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  typedef enum logic {
    STABLE_LO = 1'b0,
    STABLE_HI = 1'b1
  } stable_state_t;

  function automatic logic rise_enabled(input logic [1:0] mode);
    return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
  endfunction

  function automatic logic fall_enabled(input logic [1:0] mode);
    return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One conditioned channel: synchroniser, debounce FSM, registered edge pulses
// and a sticky event flag. state_dbg is the FSM state, which is also the debounced level.
module debounce_channel
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          level_in,
  input  logic [1:0]    edge_mode,
  input  logic          event_clear,
  output stable_state_t state_dbg,
  output logic          p_edge,
  output logic          n_edge,
  output logic          event_pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  stable_state_t          state;

  // Raw input goes straight into the first flop; nothing combinational ahead of it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], level_in};
  end

  assign synced    = sync_q[SYNC_STAGES-1];
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= STABLE_LO;
      cnt    <= '0;
      p_edge <= 1'b0;
      n_edge <= 1'b0;
    end else begin
      p_edge <= 1'b0;
      n_edge <= 1'b0;
      if (synced == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Level has differed long enough: commit and report the edge if enabled now.
        cnt <= '0;
        case (state)
          STABLE_LO: begin
            state  <= STABLE_HI;
            p_edge <= rise_enabled(edge_mode);
          end
          default: begin
            state  <= STABLE_LO;
            n_edge <= fall_enabled(edge_mode);
          end
        endcase
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // A new edge beats a simultaneous clear so no event is ever lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 event_pending <= 1'b0;
    else if (p_edge || n_edge) event_pending <= 1'b1;
    else if (event_clear)      event_pending <= 1'b0;
  end

endmodule

// File: rtl/debounced_edge_detector.sv
// Multi-channel button/level conditioner: CHANNELS independent debounce_channel
// instances plus the per-channel any_edge OR.
module debounced_edge_detector
  import edge_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level_in,
  input  logic [2*CHANNELS-1:0] edge_mode,
  input  logic [CHANNELS-1:0]   event_clear,
  output logic [CHANNELS-1:0]   level_out,
  output logic [CHANNELS-1:0]   p_edge,
  output logic [CHANNELS-1:0]   n_edge,
  output logic [CHANNELS-1:0]   any_edge,
  output logic [CHANNELS-1:0]   event_pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    stable_state_t ch_state;

    debounce_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .level_in     (level_in[i]),
      .edge_mode    (edge_mode[2*i+1:2*i]),
      .event_clear  (event_clear[i]),
      .state_dbg    (ch_state),
      .p_edge       (p_edge[i]),
      .n_edge       (n_edge[i]),
      .event_pending(event_pending[i])
    );

    assign level_out[i] = ch_state;
  end

  assign any_edge = p_edge | n_edge;

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Self-checking bench for debounced_edge_detector: directed scenarios with literal
// expectations, then randomized stimulus checked every cycle against a behavioural model.
module tb_debounced_edge_detector;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int DEB  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [CH-1:0]   level_in, event_clear;
  logic [2*CH-1:0] edge_mode;
  logic [CH-1:0]   level_out, p_edge, n_edge, any_edge, event_pending;

  debounced_edge_detector #(
    .CHANNELS       (CH),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .level_in     (level_in),
    .edge_mode    (edge_mode),
    .event_clear  (event_clear),
    .level_out    (level_out),
    .p_edge       (p_edge),
    .n_edge       (n_edge),
    .any_edge     (any_edge),
    .event_pending(event_pending)
  );

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each channel sees its raw level SYNC samples late; the debounced level flips once the
  // delayed level has disagreed with it for DEB consecutive samples.
  bit         m_pipe[CH][$];
  int         m_run[CH];
  logic [CH-1:0] m_level, m_p, m_n, m_pend;
  logic [2:0] exp_q[$];   // expected pulses in order: {channel, rising}

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pipe[c].delete();
      repeat (SYNC) m_pipe[c].push_back(1'b0);
      m_run[c] = 0;
    end
    m_level = '0;
    m_p     = '0;
    m_n     = '0;
    m_pend  = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [CH-1:0] any_prev;
    logic [1:0]    mode;
    bit            s;
    any_prev = m_p | m_n;
    m_pend   = any_prev | (m_pend & ~event_clear);
    for (int c = 0; c < CH; c++) begin
      s = m_pipe[c][0];
      m_pipe[c].push_back(level_in[c]);
      void'(m_pipe[c].pop_front());
      m_p[c] = 1'b0;
      m_n[c] = 1'b0;
      if (s != m_level[c]) begin
        m_run[c]++;
        if (m_run[c] == DEB) begin
          m_run[c]   = 0;
          m_level[c] = s;
          mode       = edge_mode[2*c +: 2];
          if (s) m_p[c] = mode[0];
          else   m_n[c] = mode[1];
          if (m_p[c] || m_n[c]) exp_q.push_back({2'(c), s});
        end
      end else begin
        m_run[c] = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else       model_step();
    end
  end

  // ---------------- compare process ----------------
  logic [2:0] got_pulse;
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("level_out", 8'(level_out), 8'(m_level));
        check("p_edge", 8'(p_edge), 8'(m_p));
        check("n_edge", 8'(n_edge), 8'(m_n));
        check("any_edge", 8'(any_edge), 8'(m_p | m_n));
        check("event_pending", 8'(event_pending), 8'(m_pend));
        for (int c = 0; c < CH; c++) begin
          if (any_edge[c]) begin
            if (exp_q.size() == 0) begin
              check("pulse_unexpected", 8'(c), 8'hff);
            end else begin
              got_pulse = {2'(c), p_edge[c]};
              check("pulse_order", 8'(got_pulse), 8'(exp_q.pop_front()));
            end
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b1;
    level_in    = 4'b0001;
    event_clear = '0;
    edge_mode   = 8'b11_10_11_01;

    // 1: input high through reset -> power-up rising edge on the 6th edge after release
    repeat (3) step();
    cmp_en = 1'b1;
    check("reset_level", 8'(level_out), 8'h0);
    check("reset_pending", 8'(event_pending), 8'h0);
    reset = 1'b0;
    repeat (5) step();
    check("t1_early", 8'(level_out), 8'h0);
    step();
    check("t1_level", 8'(level_out), 8'h1);
    check("t1_p_edge", 8'(p_edge), 8'h1);
    check("t1_pend_late", 8'(event_pending), 8'h0);
    step();
    check("t1_pending", 8'(event_pending), 8'h1);
    check("t1_p_one_cycle", 8'(p_edge), 8'h0);

    // 2: 3-cycle glitch rejected, 4+ cycles accepted
    level_in[1] = 1'b1;
    repeat (3) step();
    level_in[1] = 1'b0;
    repeat (8) step();
    check("t2_glitch", 8'(level_out[1]), 8'h0);
    level_in[1] = 1'b1;
    repeat (5) step();
    check("t2_wait", 8'(level_out[1]), 8'h0);
    step();
    check("t2_p_edge", 8'(p_edge), 8'h2);
    check("t2_level", 8'(level_out[1]), 8'h1);
    step();
    check("t2_p_one_cycle", 8'(p_edge), 8'h0);

    // 3: falling-only channel
    level_in[2] = 1'b1;
    repeat (6) step();
    check("t3_level_hi", 8'(level_out[2]), 8'h1);
    check("t3_no_p", 8'(p_edge[2]), 8'h0);
    repeat (4) step();
    level_in[2] = 1'b0;
    repeat (5) step();
    check("t3_still_hi", 8'(level_out[2]), 8'h1);
    step();
    check("t3_n_edge", 8'(n_edge), 8'h4);
    check("t3_level_lo", 8'(level_out[2]), 8'h0);
    step();
    event_clear = 4'b1111;
    step();
    event_clear = '0;
    check("t3_cleared", 8'(event_pending), 8'h0);

    // 4: clear coincident with a new edge -> set wins; clear alone -> 0
    edge_mode[1:0] = 2'b11;
    level_in[0]    = 1'b0;
    repeat (6) step();
    check("t4_n_edge", 8'(n_edge), 8'h1);
    check("t4_any_edge", 8'(any_edge), 8'h1);
    event_clear = 4'b0001;
    step();
    check("t4_set_wins", 8'(event_pending[0]), 8'h1);
    step();
    check("t4_clear", 8'(event_pending[0]), 8'h0);
    event_clear = '0;

    // 5: reset mid-count clears everything asynchronously
    level_in[3] = 1'b1;
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    check("t5_async_level", 8'(level_out), 8'h0);
    check("t5_async_pend", 8'(event_pending), 8'h0);
    check("t5_async_edges", 8'(any_edge), 8'h0);
    level_in = '0;
    repeat (2) step();
    reset = 1'b0;
    repeat (12) step();
    check("t5_quiet_level", 8'(level_out), 8'h0);
    check("t5_quiet_pend", 8'(event_pending), 8'h0);

    // 6: mode off -> level tracks, no pulses or pending
    edge_mode[1:0] = 2'b00;
    level_in[0]    = 1'b1;
    repeat (6) step();
    check("t6_level_hi", 8'(level_out[0]), 8'h1);
    check("t6_no_edge", 8'(any_edge[0]), 8'h0);
    repeat (4) step();
    level_in[0] = 1'b0;
    repeat (6) step();
    check("t6_level_lo", 8'(level_out[0]), 8'h0);
    check("t6_no_pend", 8'(event_pending[0]), 8'h0);

    // randomized phase
    repeat (2000) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 7) == 0) level_in[c] = ~level_in[c];
      if ($urandom_range(0, 63) == 0) edge_mode = 8'($urandom);
      event_clear = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      step();
    end
    level_in    = '0;
    event_clear = '0;
    repeat (12) step();
    @(negedge clk);
    #1;
    check("pulse_q_drain", 8'(exp_q.size()), 8'h0);
    cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
